// File: rtl/fetch_stage_pkg.sv
// ----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared header for the front-end pipeline: datapath widths used across the
// ALU / decoder / exception logic, and the fetch-stage FSM encoding, default
// PC step and canonical NOP word.
// No ports (package).
// ----------------------------------------------------------------------------
package fetch_stage_pkg;

    // Datapath widths shared with downstream stages.
    localparam int unsigned XLEN          = 32;
    localparam int unsigned ILEN          = 32;
    localparam int unsigned OPCODE_WIDTH  = 7;
    localparam int unsigned ALU_OP_WIDTH  = 4;
    localparam int unsigned EXC_CODE_WIDTH = 4;

    // Fetch-stage constants.
    localparam int unsigned FS_PC_STEP     = 4;
    localparam logic [31:0] FS_NOP         = 32'h0000_0013;
    localparam int unsigned FS_STATE_WIDTH = 2;

    typedef enum logic [FS_STATE_WIDTH-1:0] {
        FS_IDLE  = 2'd0,
        FS_ISSUE = 2'd1,
        FS_WAIT  = 2'd2
    } fs_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// ----------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry {instr, pc} holding register that parks a fetched word while the
// output register is stalled.
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   push              load push_instr/push_pc, entry becomes valid
//   pop               release the entry (push in the same cycle replaces it)
//   clear             drop the entry; overrides push and pop
//   push_instr/pc     data to park
//   valid             entry holds data
//   instr/pc          parked data
// ----------------------------------------------------------------------------
module fetch_skid_buffer
    import fetch_stage_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned IWIDTH   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic                clear,
    input  logic [IWIDTH-1:0]   push_instr,
    input  logic [PC_WIDTH-1:0] push_pc,
    output logic                valid,
    output logic [IWIDTH-1:0]   instr,
    output logic [PC_WIDTH-1:0] pc
);

    logic                valid_q, valid_d;
    logic [IWIDTH-1:0]   instr_q, instr_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
            instr_d = push_instr;
            pc_d    = push_pc;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// First pipeline stage. Owns the PC, fetches one instruction at a time from
// instruction memory and presents {instr, pc} with a valid strobe to the
// decoder. A one-entry skid buffer absorbs a downstream stall; flush/redirect
// kills the presented word, the parked word and any in-flight fetch.
// Ports:
//   fs_clk, fs_rst      clock / asynchronous active-low reset
//   fs_o_imem_req       1-cycle request pulse, fs_o_imem_addr valid same cycle
//   fs_o_imem_addr      fetch address (the PC register)
//   fs_i_imem_ack       response strobe, fs_i_imem_instr valid with it
//   fs_i_imem_instr     instruction word from memory
//   fs_o_instr/fs_o_pc  instruction and its PC to the decoder
//   fs_o_ce             fs_o_instr/fs_o_pc valid
//   fs_i_stall          downstream stall: hold outputs
//   fs_i_flush          redirect to fs_i_new_pc, kill fetched/in-flight words
//   fs_i_new_pc         redirect target
// ----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned          PC_WIDTH = 32,
    parameter int unsigned          IWIDTH   = 32,
    parameter logic [PC_WIDTH-1:0]  PC_RESET = '0,
    parameter int unsigned          PC_STEP  = FS_PC_STEP
) (
    input  logic                fs_clk,
    input  logic                fs_rst,
    output logic                fs_o_imem_req,
    output logic [PC_WIDTH-1:0] fs_o_imem_addr,
    input  logic                fs_i_imem_ack,
    input  logic [IWIDTH-1:0]   fs_i_imem_instr,
    output logic [IWIDTH-1:0]   fs_o_instr,
    output logic [PC_WIDTH-1:0] fs_o_pc,
    output logic                fs_o_ce,
    input  logic                fs_i_stall,
    input  logic                fs_i_flush,
    input  logic [PC_WIDTH-1:0] fs_i_new_pc
);

    localparam logic [PC_WIDTH-1:0] PcStep = PC_WIDTH'(PC_STEP);

    fs_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                discard_q, discard_d;
    logic [IWIDTH-1:0]   out_instr_q, out_instr_d;
    logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
    logic                out_ce_q, out_ce_d;

    logic                req;
    logic                deliver;
    logic                skid_push, skid_pop, skid_clear, skid_valid;
    logic [IWIDTH-1:0]   skid_instr;
    logic [PC_WIDTH-1:0] skid_pc;

    fetch_skid_buffer #(
        .PC_WIDTH (PC_WIDTH),
        .IWIDTH   (IWIDTH)
    ) u_skid (
        .clk        (fs_clk),
        .rst_n      (fs_rst),
        .push       (skid_push),
        .pop        (skid_pop),
        .clear      (skid_clear),
        .push_instr (fs_i_imem_instr),
        .push_pc    (pc_q),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        discard_d   = discard_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_ce_d    = out_ce_q;
        req         = 1'b0;
        deliver     = 1'b0;
        skid_push   = 1'b0;
        skid_pop    = 1'b0;
        skid_clear  = 1'b0;

        unique case (state_q)
            FS_IDLE: begin
                state_d = FS_ISSUE;
            end
            FS_ISSUE: begin
                // A full skid means the next word would have nowhere to go.
                req = !skid_valid && !fs_i_flush;
                if (req) begin
                    state_d = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (fs_i_imem_ack) begin
                    state_d   = FS_ISSUE;
                    discard_d = 1'b0;
                    deliver   = !discard_q && !fs_i_flush;
                end else if (fs_i_flush) begin
                    // Response still owed by memory; swallow it when it lands.
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase

        if (fs_i_flush) begin
            pc_d       = fs_i_new_pc;
            out_ce_d   = 1'b0;
            skid_clear = 1'b1;
        end else begin
            if (deliver) begin
                pc_d = pc_q + PcStep;
            end
            if (!fs_i_stall) begin
                if (skid_valid) begin
                    // Parked word is older; it goes out first.
                    out_instr_d = skid_instr;
                    out_pc_d    = skid_pc;
                    out_ce_d    = 1'b1;
                    skid_pop    = 1'b1;
                    skid_push   = deliver;
                end else if (deliver) begin
                    out_instr_d = fs_i_imem_instr;
                    out_pc_d    = pc_q;
                    out_ce_d    = 1'b1;
                end else begin
                    out_ce_d = 1'b0;
                end
            end else if (deliver) begin
                if (!out_ce_q) begin
                    out_instr_d = fs_i_imem_instr;
                    out_pc_d    = pc_q;
                    out_ce_d    = 1'b1;
                end else begin
                    skid_push = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge fs_clk or negedge fs_rst) begin
        if (!fs_rst) begin
            state_q     <= FS_IDLE;
            pc_q        <= PC_RESET;
            discard_q   <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            out_ce_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            discard_q   <= discard_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_ce_q    <= out_ce_d;
        end
    end

    assign fs_o_imem_req  = req;
    assign fs_o_imem_addr = pc_q;
    assign fs_o_instr     = out_instr_q;
    assign fs_o_pc        = out_pc_q;
    assign fs_o_ce        = out_ce_q;

endmodule
